// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result codes
// and the step-count helper.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [1:0] {RES_NONE, RES_EQ, RES_GT, RES_LT} result_e;

  function automatic int cmp_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake bundle for seq_magnitude_comparator: operand channel in, flag channel out.
// min_val/max_val exist only when SEQ_CMP_MINMAX_EN is defined.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             equal;
  logic             greater;
  logic             less;
`ifdef SEQ_CMP_MINMAX_EN
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
`endif

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, equal, greater, less
`ifdef SEQ_CMP_MINMAX_EN
    , input min_val, max_val
`endif
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, equal, greater, less
`ifdef SEQ_CMP_MINMAX_EN
    , output min_val, max_val
`endif
  );

endinterface

// File: rtl/seq_magnitude_comparator_digit_slice.sv
// One-digit unsigned compare; the top module feeds it the currently selected digit.
module cmp_digit_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial MSB-first magnitude comparator with early exit and valid/ready handshakes.
// Optional min/max outputs are built when SEQ_CMP_MINMAX_EN is defined.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_magnitude_comparator_if.slave   bus
);

  localparam int STEPS  = cmp_steps(WIDTH, DIGIT);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_magnitude_comparator: WIDTH must be >= 2");
  end
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_magnitude_comparator: DIGIT must be in 1..WIDTH and divide WIDTH");
  end

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              sgn_q, sgn_d;
  result_e           res_q, res_d;
`ifdef SEQ_CMP_MINMAX_EN
  logic [WIDTH-1:0]  min_q, min_d;
  logic [WIDTH-1:0]  max_q, max_d;
`endif

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  logic [WIDTH-1:0] a_off, b_off, a_sh, b_sh;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_eq, dig_gt, dig_lt;

  assign a_off = {a_q[WIDTH-1] ^ sgn_q, a_q[WIDTH-2:0]};
  assign b_off = {b_q[WIDTH-1] ^ sgn_q, b_q[WIDTH-2:0]};
  assign a_sh  = a_off << (int'(step_q) * DIGIT);
  assign b_sh  = b_off << (int'(step_q) * DIGIT);
  assign a_dig = a_sh[WIDTH-1 -: DIGIT];
  assign b_dig = b_sh[WIDTH-1 -: DIGIT];

  cmp_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i  (a_dig),
    .b_i  (b_dig),
    .eq_o (dig_eq),
    .gt_o (dig_gt),
    .lt_o (dig_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      res_q   <= RES_NONE;
`ifdef SEQ_CMP_MINMAX_EN
      min_q   <= '0;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
`ifdef SEQ_CMP_MINMAX_EN
      min_q   <= min_d;
      max_q   <= max_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
`ifdef SEQ_CMP_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          step_d  = '0;
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.is_signed;
        end
      end
      RUN: begin
        if (!dig_eq || step_q == LAST_STEP) begin
          state_d = DONE;
          res_d   = dig_gt ? RES_GT : (dig_lt ? RES_LT : RES_EQ);
`ifdef SEQ_CMP_MINMAX_EN
          min_d   = dig_gt ? b_q : a_q;
          max_d   = dig_gt ? a_q : b_q;
`endif
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE: begin
        // Results are cleared on drain so flags read zero outside DONE.
        if (bus.out_ready) begin
          state_d = IDLE;
          res_d   = RES_NONE;
`ifdef SEQ_CMP_MINMAX_EN
          min_d   = '0;
          max_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.equal     = (res_q == RES_EQ);
    bus.greater   = (res_q == RES_GT);
    bus.less      = (res_q == RES_LT);
`ifdef SEQ_CMP_MINMAX_EN
    bus.min_val   = min_q;
    bus.max_val   = max_q;
`endif
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: a 16/4 instance and a 3/1 instance checked
// every cycle against a transaction-level model, plus directed literal cases.
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(16)) i16 ();
  seq_magnitude_comparator_if #(.WIDTH(3))  i3  ();

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(i16));
  seq_magnitude_comparator #(.WIDTH(3),  .DIGIT(1)) u3  (.clk(clk), .rst(rst), .bus(i3));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result code from plain integer comparison: 1 equal, 2 greater, 3 less.
  function automatic int ref_code(input int w, input logic [31:0] a, input logic [31:0] b, input bit s);
    longint va, vb;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (64'sd1 <<< w);
    if (s && b[w-1]) vb = vb - (64'sd1 <<< w);
    if (va == vb) return 1;
    return (va > vb) ? 2 : 3;
  endfunction

  // Edges from accept to result: 1-based index of first differing digit, else the step count.
  function automatic int ref_k(input int w, input int d, input logic [31:0] a, input logic [31:0] b);
    longint m;
    m = (64'sd1 <<< d) - 1;
    for (int i = 1; i <= w / d; i++) begin
      if (((longint'(a) >> (w - i * d)) & m) != ((longint'(b) >> (w - i * d)) & m)) return i;
    end
    return w / d;
  endfunction

  // Model per instance: phase 0 idle, 1 busy, 2 result held.
  int          m_ph [2];
  int          m_cnt[2];
  int          m_res[2];
  logic [31:0] m_a  [2];
  logic [31:0] m_b  [2];

  task automatic model_step(input int idx, input int w, input int d, input logic iv,
                            input logic [31:0] a, input logic [31:0] b, input logic s, input logic ordy);
    case (m_ph[idx])
      0: if (iv) begin
        m_ph[idx]  = 1;
        m_cnt[idx] = ref_k(w, d, a, b);
        m_res[idx] = ref_code(w, a, b, s);
        m_a[idx]   = a;
        m_b[idx]   = b;
      end
      1: begin
        m_cnt[idx]--;
        if (m_cnt[idx] == 0) m_ph[idx] = 2;
      end
      default: if (ordy) m_ph[idx] = 0;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          m_ph[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_a[i] = '0; m_b[i] = '0;
        end
      end else begin
        model_step(0, 16, 4, i16.in_valid, 32'(i16.a), 32'(i16.b), i16.is_signed, i16.out_ready);
        model_step(1, 3, 1, i3.in_valid, 32'(i3.a), 32'(i3.b), i3.is_signed, i3.out_ready);
      end
    end
  end

  task automatic cmp_inst(input int idx, input string tag, input logic ir, input logic ov,
                          input logic eq, input logic gt, input logic lt,
                          input logic [31:0] mn, input logic [31:0] mx);
    bit done;
    done = (m_ph[idx] == 2);
    check({tag, ".in_ready"},  64'(ir), 64'(m_ph[idx] == 0));
    check({tag, ".out_valid"}, 64'(ov), 64'(done));
    check({tag, ".flags"}, 64'({eq, gt, lt}),
          64'({done && m_res[idx] == 1, done && m_res[idx] == 2, done && m_res[idx] == 3}));
    if (ov) check({tag, ".onehot"}, 64'($countones({eq, gt, lt})), 64'd1);
`ifdef SEQ_CMP_MINMAX_EN
    check({tag, ".min_val"}, 64'(mn), done ? 64'((m_res[idx] == 2) ? m_b[idx] : m_a[idx]) : 64'd0);
    check({tag, ".max_val"}, 64'(mx), done ? 64'((m_res[idx] == 2) ? m_a[idx] : m_b[idx]) : 64'd0);
`else
    if (mn != mx) check({tag, ".minmax_tie"}, 64'(mn), 64'(mx));
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
`ifdef SEQ_CMP_MINMAX_EN
        cmp_inst(0, "u16", i16.in_ready, i16.out_valid, i16.equal, i16.greater, i16.less,
                 32'(i16.min_val), 32'(i16.max_val));
        cmp_inst(1, "u3", i3.in_ready, i3.out_valid, i3.equal, i3.greater, i3.less,
                 32'(i3.min_val), 32'(i3.max_val));
`else
        cmp_inst(0, "u16", i16.in_ready, i16.out_valid, i16.equal, i16.greater, i16.less, '0, '0);
        cmp_inst(1, "u3", i3.in_ready, i3.out_valid, i3.equal, i3.greater, i3.less, '0, '0);
`endif
      end
    end
  end

  // Directed transaction on the 16-bit instance; caller is at posedge+2 with the DUT idle.
  task automatic dir16(input string nm, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int exp_k, input logic [2:0] exp_flags, input int hold);
    int lat;
    i16.in_valid = 1'b1; i16.a = a; i16.b = b; i16.is_signed = s; i16.out_ready = 1'b0;
    @(posedge clk); #2;
    i16.in_valid = 1'b0;
    i16.a = 16'h5A5A; i16.b = 16'hA5A5;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i16.out_valid) begin lat = i; break; end
    end
    check({nm, ".latency"}, 64'(lat), 64'(exp_k));
    check({nm, ".flags"}, 64'({i16.equal, i16.greater, i16.less}), 64'(exp_flags));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({nm, ".hold_valid"}, 64'(i16.out_valid), 64'd1);
      check({nm, ".hold_flags"}, 64'({i16.equal, i16.greater, i16.less}), 64'(exp_flags));
      check({nm, ".hold_in_ready"}, 64'(i16.in_ready), 64'd0);
    end
    #1 i16.out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, ".drain_in_ready"}, 64'(i16.in_ready), 64'd1);
    check({nm, ".drain_valid"}, 64'(i16.out_valid), 64'd0);
    #1 i16.out_ready = 1'b0;
  endtask

  task automatic exhaustive3();
    bit acc;
    i3.out_ready = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) begin
          i3.in_valid = 1'b1; i3.a = 3'(a); i3.b = 3'(b); i3.is_signed = s[0];
          acc = 1'b0;
          for (int t = 0; t < 20 && !acc; t++) begin
            acc = i3.in_ready;
            @(posedge clk); #2;
          end
          if (!acc) check("u3.accept_timeout", 64'd0, 64'd1);
          i3.in_valid = 1'b0;
        end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic random16(input int n);
    int r;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #2;
      r = int'($urandom_range(0, 3));
      i16.in_valid  = ($urandom_range(0, 1) == 1);
      i16.a         = 16'($urandom);
      i16.b         = (r == 0) ? i16.a : (r == 1) ? (i16.a ^ (16'd1 << $urandom_range(0, 15))) : 16'($urandom);
      i16.is_signed = ($urandom_range(0, 1) == 1);
      i16.out_ready = ($urandom_range(0, 2) != 0);
    end
    i16.in_valid = 1'b0;
    i16.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #2 i16.out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.is_signed = 1'b0; i16.out_ready = 1'b0;
    i3.in_valid  = 1'b0; i3.a  = '0; i3.b  = '0; i3.is_signed  = 1'b0; i3.out_ready  = 1'b0;

    check("model.code_u", 64'(ref_code(16, 32'h8000, 32'h7FFF, 1'b0)), 64'd2);
    check("model.code_s", 64'(ref_code(16, 32'h8000, 32'h7FFF, 1'b1)), 64'd3);
    check("model.code_s3", 64'(ref_code(3, 32'h7, 32'h0, 1'b1)), 64'd3);
    check("model.k_eq", 64'(ref_k(16, 4, 32'h1234, 32'h1234)), 64'd4);
    check("model.k_top", 64'(ref_k(16, 4, 32'h8000, 32'h7FFF)), 64'd1);
    check("model.k_w3", 64'(ref_k(3, 1, 32'h5, 32'h4)), 64'd3);

    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 64'(i16.in_ready), 64'd1);
    check("reset.out_valid", 64'(i16.out_valid), 64'd0);
    check("reset.flags", 64'({i16.equal, i16.greater, i16.less}), 64'd0);
    check("reset.u3_flags", 64'({i3.out_valid, i3.equal, i3.greater, i3.less}), 64'd0);
`ifdef SEQ_CMP_MINMAX_EN
    check("reset.minmax", 64'({i16.min_val, i16.max_val}), 64'd0);
`endif
    #1 rst = 1'b0;
    chk_en = 1'b1;

    dir16("t1_unsigned", 16'h8000, 16'h7FFF, 1'b0, 1, 3'b010, 0);
    dir16("t2_signed",   16'h8000, 16'h7FFF, 1'b1, 1, 3'b001, 0);
    dir16("t3_equal",    16'h1234, 16'h1234, 1'b0, 4, 3'b100, 0);
    dir16("t4_hold_gt",  16'h1235, 16'h1234, 1'b0, 4, 3'b010, 3);
    dir16("t_low_lt",    16'h0001, 16'h0002, 1'b0, 4, 3'b001, 1);
    dir16("t_neg_lt",    16'hFFFF, 16'h0001, 1'b1, 1, 3'b001, 0);

    // Abort in the middle of RUN: no result may ever appear for this pair.
    i16.in_valid = 1'b1; i16.a = 16'h1234; i16.b = 16'h1234; i16.is_signed = 1'b0; i16.out_ready = 1'b1;
    @(posedge clk); #2;
    i16.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t5_rst.in_ready", 64'(i16.in_ready), 64'd1);
    check("t5_rst.outs", 64'({i16.out_valid, i16.equal, i16.greater, i16.less}), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t5_rst.no_pulse", 64'(i16.out_valid), 64'd0);
    end
    #1 i16.out_ready = 1'b0;

    fork
      exhaustive3();
      random16(600);
    join

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
